// File: rtl/csr_pkg.sv
// Shared state encoding, widths and payload types for the CSR encode scheduler.
package csr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LAUNCH  = 3'd2,
    CAPTURE = 3'd3,
    COMMIT  = 3'd4,
    FINISH  = 3'd5
  } state_e;

  localparam int unsigned TILE_DIM = 6;
  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned COL_W    = 4;
  localparam int unsigned PTR_W    = 56;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned TILE_W   = TILE_DIM * TILE_DIM * ELEM_W;

  // Row-pointer word the encoder reports for a tile with no non-zero entries.
  localparam logic [PTR_W-1:0] ZERO_TILE_PTR = 56'h01010101010101;

  typedef struct packed {
    logic [ELEM_W-1:0] value;
    logic [COL_W-1:0]  col;
  } dm_entry_t;

  function automatic logic cfg_legal(input logic [CNT_W-1:0] n,
                                     input logic [COL_W-1:0] rs,
                                     input logic [CNT_W-1:0] max_n);
    return (n != '0) && (n <= max_n) && (rs != '0) && (rs <= COL_W'(TILE_DIM));
  endfunction

endpackage

// File: rtl/csr_wr_ptr_ctr.sv
// Saturating data-memory write pointer; full marks that the last address was written.
module csr_wr_ptr_ctr #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] value,
  output logic          full
);

  logic [AW-1:0] value_q, value_d;
  logic          full_q, full_d;

  always_comb begin
    value_d = value_q;
    full_d  = full_q;
    if (clr) begin
      value_d = '0;
      full_d  = 1'b0;
    end else if (inc && !full_q) begin
      if (value_q == {AW{1'b1}}) full_d  = 1'b1;
      else                       value_d = value_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      full_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      full_q  <= full_d;
    end
  end

  assign value = value_q;
  assign full  = full_q;

endmodule

// File: rtl/csr_encode_scheduler.sv
// Walks a batch of tiles through the CSR encoder, packing entries into the data
// memory and committing one row-pointer record per tile to the pointer memory.
module csr_encode_scheduler
  import csr_pkg::*;
#(
  parameter  int unsigned NUM_TILES = 16,
  parameter  int unsigned MEM_AW    = 10,
  parameter  int unsigned TIMEOUT   = 255,
  localparam int unsigned TW        = $clog2(NUM_TILES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_tiles,
  input  logic [COL_W-1:0]        row_size,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    tile_req,
  output logic [TW-1:0]           tile_idx,
  input  logic                    tile_vld,
  input  logic [TILE_W-1:0]       tile_data,
  output logic                    enc_enable,
  output logic [COL_W-1:0]        enc_row_size,
  output logic [TILE_W-1:0]       enc_data_in,
  input  logic                    enc_store,
  input  logic [ELEM_W-1:0]       enc_data,
  input  logic [COL_W-1:0]        enc_row,
  input  logic [PTR_W-1:0]        enc_index_pointer,
  input  logic                    enc_done,
  output logic                    dm_we,
  output logic [MEM_AW-1:0]       dm_addr,
  output logic [ELEM_W+COL_W-1:0] dm_wdata,
  output logic                    pm_we,
  output logic [TW-1:0]           pm_addr,
  output logic [MEM_AW+PTR_W:0]   pm_wdata
);

  localparam int unsigned TOW = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        num_tiles_q, num_tiles_d;
  logic [TW-1:0]           tile_q, tile_d;
  logic [MEM_AW-1:0]       base_q, base_d;
  logic [TOW-1:0]          to_cnt_q, to_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    tile_req_q, tile_req_d;
  logic                    enc_enable_q, enc_enable_d;
  logic [COL_W-1:0]        enc_row_size_q, enc_row_size_d;
  logic [TILE_W-1:0]       enc_data_in_q, enc_data_in_d;
  logic                    dm_we_q, dm_we_d;
  logic [MEM_AW-1:0]       dm_addr_q, dm_addr_d;
  dm_entry_t               dm_wdata_q, dm_wdata_d;
  logic                    pm_we_q, pm_we_d;
  logic [MEM_AW+PTR_W:0]   pm_wdata_q, pm_wdata_d;

  logic                    ptr_clr, ptr_inc, ptr_full;
  logic [MEM_AW-1:0]       ptr_val;

  csr_wr_ptr_ctr #(.AW(MEM_AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ptr_clr),
    .inc   (ptr_inc),
    .value (ptr_val),
    .full  (ptr_full)
  );

  always_comb begin
    state_d        = state_q;
    num_tiles_d    = num_tiles_q;
    tile_d         = tile_q;
    base_d         = base_q;
    to_cnt_d       = to_cnt_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = err_q;
    tile_req_d     = tile_req_q;
    enc_enable_d   = 1'b0;
    enc_row_size_d = enc_row_size_q;
    enc_data_in_d  = enc_data_in_q;
    dm_we_d        = 1'b0;
    dm_addr_d      = dm_addr_q;
    dm_wdata_d     = dm_wdata_q;
    pm_we_d        = 1'b0;
    pm_wdata_d     = pm_wdata_q;
    ptr_clr        = 1'b0;
    ptr_inc        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_legal(num_tiles, row_size, CNT_W'(NUM_TILES))) begin
            num_tiles_d    = num_tiles;
            enc_row_size_d = row_size;
            err_d          = 1'b0;
            tile_d         = '0;
            ptr_clr        = 1'b1;
            busy_d         = 1'b1;
            tile_req_d     = 1'b1;
            state_d        = FETCH;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (tile_vld && tile_req_q) begin
          tile_req_d    = 1'b0;
          enc_data_in_d = tile_data;
          base_d        = ptr_val;
          enc_enable_d  = 1'b1;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        // A store arriving with enc_done still lands before the commit.
        if (enc_store) begin
          ptr_inc = 1'b1;
          if (ptr_full) begin
            err_d = 1'b1;
          end else begin
            dm_we_d          = 1'b1;
            dm_addr_d        = ptr_val;
            dm_wdata_d.value = enc_data;
            dm_wdata_d.col   = enc_row;
          end
        end
        if (enc_done) begin
          pm_we_d    = 1'b1;
          pm_wdata_d = {enc_index_pointer == ZERO_TILE_PTR, base_q, enc_index_pointer};
          state_d    = COMMIT;
        end else if (to_cnt_q == TOW'(TIMEOUT)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      COMMIT: begin
        if (CNT_W'(tile_q) == num_tiles_q - CNT_W'(1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else begin
          tile_d     = tile_q + TW'(1);
          tile_req_d = 1'b1;
          state_d    = FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      num_tiles_q    <= '0;
      tile_q         <= '0;
      base_q         <= '0;
      to_cnt_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      tile_req_q     <= 1'b0;
      enc_enable_q   <= 1'b0;
      enc_row_size_q <= '0;
      enc_data_in_q  <= '0;
      dm_we_q        <= 1'b0;
      dm_addr_q      <= '0;
      dm_wdata_q     <= '0;
      pm_we_q        <= 1'b0;
      pm_wdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      num_tiles_q    <= num_tiles_d;
      tile_q         <= tile_d;
      base_q         <= base_d;
      to_cnt_q       <= to_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      tile_req_q     <= tile_req_d;
      enc_enable_q   <= enc_enable_d;
      enc_row_size_q <= enc_row_size_d;
      enc_data_in_q  <= enc_data_in_d;
      dm_we_q        <= dm_we_d;
      dm_addr_q      <= dm_addr_d;
      dm_wdata_q     <= dm_wdata_d;
      pm_we_q        <= pm_we_d;
      pm_wdata_q     <= pm_wdata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign tile_req     = tile_req_q;
  assign tile_idx     = tile_q;
  assign enc_enable   = enc_enable_q;
  assign enc_row_size = enc_row_size_q;
  assign enc_data_in  = enc_data_in_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;
  assign pm_we        = pm_we_q;
  assign pm_addr      = tile_q;
  assign pm_wdata     = pm_wdata_q;

endmodule

// File: tb/tb_csr_encode_scheduler.sv
// Scoreboard bench: a full-size scheduler and a MEM_AW=3 copy run in lockstep on shared inputs.
module tb_csr_encode_scheduler;

  localparam int unsigned TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   num_tiles = '0;
  logic [3:0]   row_size = '0;
  logic         tile_vld = 1'b0;
  logic [287:0] tile_data = '0;
  logic         enc_store = 1'b0;
  logic [7:0]   enc_data = '0;
  logic [3:0]   enc_row = '0;
  logic [55:0]  enc_index_pointer = '0;
  logic         enc_done = 1'b0;

  logic         busy, done, err, tile_req, enc_enable, dm_we, pm_we;
  logic [3:0]   tile_idx, enc_row_size, pm_addr;
  logic [287:0] enc_data_in;
  logic [9:0]   dm_addr;
  logic [11:0]  dm_wdata;
  logic [66:0]  pm_wdata;

  logic         busy_s, done_s, err_s, tile_req_s, enc_enable_s, dm_we_s, pm_we_s;
  logic [3:0]   tile_idx_s, enc_row_size_s, pm_addr_s;
  logic [287:0] enc_data_in_s;
  logic [2:0]   dm_addr_s;
  logic [11:0]  dm_wdata_s;
  logic [59:0]  pm_wdata_s;

  csr_encode_scheduler #(.NUM_TILES(16), .MEM_AW(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .row_size(row_size),
    .busy(busy), .done(done), .err(err), .tile_req(tile_req), .tile_idx(tile_idx),
    .tile_vld(tile_vld), .tile_data(tile_data), .enc_enable(enc_enable),
    .enc_row_size(enc_row_size), .enc_data_in(enc_data_in), .enc_store(enc_store),
    .enc_data(enc_data), .enc_row(enc_row), .enc_index_pointer(enc_index_pointer),
    .enc_done(enc_done), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata)
  );

  csr_encode_scheduler #(.NUM_TILES(16), .MEM_AW(3), .TIMEOUT(TIMEOUT)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .row_size(row_size),
    .busy(busy_s), .done(done_s), .err(err_s), .tile_req(tile_req_s), .tile_idx(tile_idx_s),
    .tile_vld(tile_vld), .tile_data(tile_data), .enc_enable(enc_enable_s),
    .enc_row_size(enc_row_size_s), .enc_data_in(enc_data_in_s), .enc_store(enc_store),
    .enc_data(enc_data), .enc_row(enc_row), .enc_index_pointer(enc_index_pointer),
    .enc_done(enc_done), .dm_we(dm_we_s), .dm_addr(dm_addr_s), .dm_wdata(dm_wdata_s),
    .pm_we(pm_we_s), .pm_addr(pm_addr_s), .pm_wdata(pm_wdata_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int enc_pulses = 0, dm_cnt = 0, dm_cnt_s = 0, pm_cnt = 0, done_cnt = 0;
  int pm_cyc = 0, launch_cyc = 0, done_at = 0;
  logic [9:0] last_dm_addr = '0;

  logic [21:0] dm_q[$];
  logic [14:0] dm_qs[$];
  logic [70:0] pm_q[$];

  logic [9:0] m_ptr;
  logic       m_full, m_err;
  logic [2:0] s_ptr;
  logic       s_full, s_err;
  logic [3:0] exp_rs;

  always @(posedge clk) cyc++;

  // Output monitors: every memory write must match the head of its scoreboard queue.
  always @(negedge clk) begin
    logic [21:0] de;
    logic [14:0] se;
    logic [70:0] pe;
    if (enc_enable) enc_pulses++;
    if (done) done_cnt++;
    if (dm_we) begin
      checks++; dm_cnt++; last_dm_addr = dm_addr;
      if (dm_q.size() == 0) begin
        errors++; $display("FAIL dm_write: got addr=%0d data=%h, required no write", dm_addr, dm_wdata);
      end else begin
        de = dm_q.pop_front();
        if ({dm_addr, dm_wdata} !== de) begin
          errors++; $display("FAIL dm_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             dm_addr, dm_wdata, de[21:12], de[11:0]);
        end
      end
    end
    if (dm_we_s) begin
      checks++; dm_cnt_s++;
      if (dm_qs.size() == 0) begin
        errors++; $display("FAIL dm_write_small: got addr=%0d data=%h, required no write", dm_addr_s, dm_wdata_s);
      end else begin
        se = dm_qs.pop_front();
        if ({dm_addr_s, dm_wdata_s} !== se) begin
          errors++; $display("FAIL dm_write_small: got addr=%0d data=%h, required addr=%0d data=%h",
                             dm_addr_s, dm_wdata_s, se[14:12], se[11:0]);
        end
      end
    end
    if (pm_we) begin
      checks++; pm_cnt++; pm_cyc = cyc;
      if (pm_q.size() == 0) begin
        errors++; $display("FAIL pm_write: got addr=%0d data=%h, required no write", pm_addr, pm_wdata);
      end else begin
        pe = pm_q.pop_front();
        if ({pm_addr, pm_wdata} !== pe) begin
          errors++; $display("FAIL pm_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             pm_addr, pm_wdata, pe[70:67], pe[66:0]);
        end
      end
    end
  end

  function automatic logic [287:0] diag_tile();
    logic [287:0] t;
    t = '0;
    for (int r = 0; r < 6; r++) t[287 - 8*(r*7) -: 8] = 8'(r + 1);
    return t;
  endfunction

  function automatic logic [287:0] rand_tile();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_store(input logic [7:0] v, input logic [3:0] c);
    if (m_full) m_err = 1'b1;
    else begin
      dm_q.push_back({m_ptr, v, c});
      if (m_ptr == 10'h3FF) m_full = 1'b1; else m_ptr = m_ptr + 10'd1;
    end
    if (s_full) s_err = 1'b1;
    else begin
      dm_qs.push_back({s_ptr, v, c});
      if (s_ptr == 3'h7) s_full = 1'b1; else s_ptr = s_ptr + 3'd1;
    end
  endtask

  task automatic do_start(input logic [4:0] nt, input logic [3:0] rs);
    start = 1'b1; num_tiles = nt; row_size = rs; exp_rs = rs;
    m_ptr = '0; m_full = 1'b0; m_err = 1'b0;
    s_ptr = '0; s_full = 1'b0; s_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Serves one fetch, then plays the encoder; entries are value v0+i at column i%6.
  task automatic run_tile(input int tix, input int delay, input logic [287:0] data, input int nnz,
                          input logic [7:0] v0, input logic [55:0] ptr, input bit fin);
    int n, req_cycles;
    logic [9:0] base;
    n = 0;
    while (!tile_req && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (tile_req !== 1'b1) begin
      errors++; $display("FAIL fetch_req: tile_req=%b after %0d cycles, required 1", tile_req, n);
      return;
    end
    checks++;
    if (tile_idx !== 4'(tix)) begin
      errors++; $display("FAIL tile_idx: got %0d, required %0d", tile_idx, tix);
    end
    req_cycles = 1;
    repeat (delay) begin @(negedge clk); if (tile_req) req_cycles++; end
    tile_vld = 1'b1; tile_data = data; base = m_ptr;
    @(negedge clk);
    tile_vld = 1'b0;
    launch_cyc = cyc;
    checks++;
    if ({enc_enable, tile_req} !== 2'b10) begin
      errors++; $display("FAIL launch: enc_enable=%b tile_req=%b, required 1 0", enc_enable, tile_req);
    end
    checks++;
    if (enc_data_in !== data || enc_row_size !== exp_rs) begin
      errors++; $display("FAIL launch_payload: row_size=%0d data=%h, required row_size=%0d data=%h",
                         enc_row_size, enc_data_in, exp_rs, data);
    end
    if (delay > 0) begin
      checks++;
      if (req_cycles != delay + 1) begin
        errors++; $display("FAIL req_hold: tile_req high %0d cycles, required %0d", req_cycles, delay + 1);
      end
    end
    for (int i = 0; i < nnz; i++) begin
      @(negedge clk);
      enc_store = 1'b1; enc_data = v0 + 8'(i); enc_row = 4'(i % 6);
      push_store(v0 + 8'(i), 4'(i % 6));
      if (fin && i == nnz - 1) begin
        enc_done = 1'b1; enc_index_pointer = ptr;
        pm_q.push_back({4'(tix), ptr == 56'h01010101010101, base, ptr});
      end
    end
    if (fin && nnz == 0) begin
      @(negedge clk);
      enc_done = 1'b1; enc_index_pointer = ptr;
      pm_q.push_back({4'(tix), ptr == 56'h01010101010101, base, ptr});
    end
    @(negedge clk);
    enc_store = 1'b0; enc_done = 1'b0;
  endtask

  task automatic wait_done(input bit to);
    int n;
    n = 0;
    while (!done && n < 600) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, n);
      return;
    end
    done_at = cyc;
    checks++;
    if ({busy, err, done_s, err_s} !== {1'b0, m_err | to, 1'b1, s_err | to}) begin
      errors++; $display("FAIL done_status: busy=%b err=%b done_s=%b err_s=%b, required 0 %b 1 %b",
                         busy, err, done_s, err_s, m_err | to, s_err | to);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_width: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, tile_req, enc_enable, dm_we, pm_we, tile_idx, dm_addr, pm_wdata} !== '0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b err=%b req=%b en=%b dm_we=%b pm_we=%b, required all 0",
                         busy, done, err, tile_req, enc_enable, dm_we, pm_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, tile_req} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b req=%b, required 0 0 0", busy, done, tile_req);
    end
  endtask

  task automatic test_illegal_start();
    logic [8:0] cfg[4];
    int req_seen;
    cfg[0] = {5'd1, 4'd7}; cfg[1] = {5'd0, 4'd6}; cfg[2] = {5'd17, 4'd6}; cfg[3] = {5'd1, 4'd0};
    foreach (cfg[k]) begin
      do_start(cfg[k][8:4], cfg[k][3:0]);
      checks++;
      if ({done, err, busy, tile_req} !== 4'b1100) begin
        errors++; $display("FAIL illegal_start[%0d]: done=%b err=%b busy=%b req=%b, required 1 1 0 0",
                           k, done, err, busy, tile_req);
      end
      req_seen = 0;
      repeat (3) begin @(negedge clk); if (tile_req || done) req_seen++; end
      checks++;
      if (req_seen != 0) begin
        errors++; $display("FAIL illegal_quiet[%0d]: %0d cycles with req/done, required 0", k, req_seen);
      end
    end
  endtask

  task automatic test_identity();
    int dm0;
    dm0 = dm_cnt;
    do_start(5'd1, 4'd6);
    checks++;
    if ({busy, err} !== 2'b10) begin
      errors++; $display("FAIL start_accept: busy=%b err=%b, required 1 0", busy, err);
    end
    run_tile(0, 0, diag_tile(), 6, 8'd1, 56'h00010203040506, 1'b1);
    wait_done(1'b0);
    checks++;
    if (done_at != pm_cyc + 1) begin
      errors++; $display("FAIL done_after_pm: done at cycle %0d, required %0d", done_at, pm_cyc + 1);
    end
    checks++;
    if (dm_cnt - dm0 != 6 || dm_q.size() != 0 || pm_q.size() != 0) begin
      errors++; $display("FAIL identity_writes: %0d dm writes, %0d/%0d pending, required 6 and 0/0",
                         dm_cnt - dm0, dm_q.size(), pm_q.size());
    end
  endtask

  task automatic test_three_tiles();
    int dm0, pm0, en0;
    dm0 = dm_cnt; pm0 = pm_cnt; en0 = enc_pulses;
    do_start(5'd3, 4'd6);
    run_tile(0, 0, rand_tile(), 4, 8'h10, 56'h00010203040404, 1'b1);
    run_tile(1, 0, '0, 0, 8'h00, 56'h01010101010101, 1'b1);
    run_tile(2, 3, rand_tile(), 9, 8'h40, 56'h00020406080909, 1'b1);
    wait_done(1'b0);
    checks++;
    if (dm_cnt - dm0 != 13 || last_dm_addr !== 10'd12) begin
      errors++; $display("FAIL three_tiles_ptr: %0d writes ending at addr %0d, required 13 ending at 12",
                         dm_cnt - dm0, last_dm_addr);
    end
    checks++;
    if (pm_cnt - pm0 != 3 || enc_pulses - en0 != 3 || pm_q.size() != 0 || dm_qs.size() != 0) begin
      errors++; $display("FAIL three_tiles_pm: %0d pm writes, %0d launches, %0d/%0d pending, required 3 3 0 0",
                         pm_cnt - pm0, enc_pulses - en0, pm_q.size(), dm_qs.size());
    end
  endtask

  task automatic test_slow_fetch();
    int en0;
    en0 = enc_pulses;
    do_start(5'd1, 4'd4);
    run_tile(0, 20, rand_tile(), 3, 8'h21, 56'h00010203030303, 1'b1);
    wait_done(1'b0);
    checks++;
    if (enc_pulses - en0 != 1) begin
      errors++; $display("FAIL slow_fetch_launch: %0d enc_enable cycles, required 1", enc_pulses - en0);
    end
  endtask

  task automatic test_timeout();
    int pm0;
    pm0 = pm_cnt;
    do_start(5'd2, 4'd6);
    run_tile(0, 0, rand_tile(), 0, 8'h00, 56'h0, 1'b0);
    wait_done(1'b1);
    checks++;
    if (done_at - launch_cyc - 1 != TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_len: %0d capture cycles, required %0d", done_at - launch_cyc - 1, TIMEOUT + 1);
    end
    checks++;
    if (pm_cnt != pm0 || tile_req !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: %0d pm writes, tile_req=%b, required 0 and 0", pm_cnt - pm0, tile_req);
    end
  endtask

  task automatic test_overflow();
    int ds0;
    ds0 = dm_cnt_s;
    do_start(5'd1, 4'd6);
    run_tile(0, 0, rand_tile(), 9, 8'h70, 56'h00020304060809, 1'b1);
    wait_done(1'b0);
    checks++;
    if (dm_cnt_s - ds0 != 8 || dm_qs.size() != 0 || err_s !== 1'b1) begin
      errors++; $display("FAIL overflow: %0d small writes, %0d pending, err_s=%b, required 8 0 1",
                         dm_cnt_s - ds0, dm_qs.size(), err_s);
    end
  endtask

  task automatic test_reset_mid_capture();
    int d0;
    do_start(5'd2, 4'd6);
    run_tile(0, 0, rand_tile(), 1, 8'h55, 56'h0, 1'b0);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, tile_req, enc_enable, dm_we, pm_we, tile_idx, dm_addr, dm_wdata,
         pm_wdata, enc_row_size} !== '0 || enc_data_in !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b err=%b dm_we=%b dm_addr=%0d data_in=%h, required all 0",
                         busy, done, err, dm_we, dm_addr, enc_data_in);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_done: %0d done pulses, busy=%b, required 0 and 0", done_cnt - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_illegal_start();
    test_identity();
    test_three_tiles();
    test_slow_fetch();
    test_timeout();
    test_overflow();
    test_reset_mid_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
